// File: rtl/swap_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// swap_scheduler_pkg
// Shared definitions for the swap scheduler slice.
//   state_e  : FSM states of the swap sequencer (IDLE -> GRANT -> LOAD -> WRITE)
//   rst_val  : reset contents of register i, i.e. 10*(i+1); callers truncate
//              the result to their data width, which gives the mod 2**DW wrap.
// ----------------------------------------------------------------------------
package swap_scheduler_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_LOAD  = 2'd2,
        S_WRITE = 2'd3
    } state_e;

    // Reset value of bank entry i before truncation to the bank width.
    function automatic int rst_val(input int i);
        return 10 * (i + 1);
    endfunction

endpackage

// File: rtl/swap_scheduler_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. The requester at position ptr_i has the
// highest priority, then ptr_i+1, and so on, wrapping modulo N.
// Ports:
//   req_i   [N]   request vector
//   ptr_i   [IW]  index of the highest-priority requester
//   grant_o [N]   one-hot winner (all zero when nobody requests)
//   idx_o   [IW]  binary index of the winner (0 when nobody requests)
//   valid_o       at least one request is present
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    logic [N-1:0] rotated;

    // Rotate the requests so that bit 0 is the requester at ptr_i, then pick
    // the lowest set bit. Scanning downwards lets the smallest offset be the
    // last (and therefore winning) assignment. The winner's absolute index is
    // the offset added back onto the pointer, modulo N.
    always_comb begin
        rotated = N'({req_i, req_i} >> ptr_i);
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int off = N - 1; off >= 0; off--) begin
            if (rotated[off]) begin
                valid_o = 1'b1;
                idx_o   = IW'((int'(ptr_i) + off) % N);
            end
        end
        if (valid_o) begin
            grant_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/swap_scheduler.sv
// ----------------------------------------------------------------------------
// swap_scheduler
// Owns a small register bank and a single swap datapath (a pair of temps).
// N_REQ requesters each ask to exchange two bank entries by index; a
// round-robin arbiter admits one request at a time and a four-state FSM
// sequences the swap: grant, latch temps, write back, report done.
// Ports:
//   clk_i        clock, all state changes on the rising edge
//   rst_i        synchronous active-high reset
//   req_i        [N_REQ]     per-requester swap request, held until granted
//   idx_a_i      [N_REQ*AW]  packed first index, slice i for requester i
//   idx_b_i      [N_REQ*AW]  packed second index, slice i for requester i
//   gnt_o        [N_REQ]     one-hot, single-cycle grant pulse
//   busy_o                   high whenever a swap is in flight
//   done_o                   single-cycle completion pulse
//   done_id_o    [IW]        requester served, valid with done_o
//   err_o                    pulses with done_o when an index was out of range
//   rd_idx_i     [AW]        observation read address
//   rd_data_o    [DW]        combinational bank[rd_idx_i], 0 when out of range
// ----------------------------------------------------------------------------
module swap_scheduler
    import swap_scheduler_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int N_REGS = 8,
    parameter int AW     = 3,
    parameter int DW     = 8,
    localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [N_REQ-1:0]    req_i,
    input  logic [N_REQ*AW-1:0] idx_a_i,
    input  logic [N_REQ*AW-1:0] idx_b_i,
    output logic [N_REQ-1:0]    gnt_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [IW-1:0]       done_id_o,
    output logic                err_o,
    input  logic [AW-1:0]       rd_idx_i,
    output logic [DW-1:0]       rd_data_o
);

    state_e              state_q, state_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [IW-1:0]       winIdx_q;
    logic [N_REQ-1:0]    winGnt_q;
    logic [AW-1:0]       aIdx_q, bIdx_q;
    logic [DW-1:0]       tempA_q, tempB_q;
    logic [DW-1:0]       regs_q [N_REGS];

    logic [N_REQ-1:0]    arbGnt;
    logic [IW-1:0]       arbIdx;
    logic                arbValid;
    logic                idxErr;
    logic [DW-1:0]       regA, regB;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_arbiter (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .grant_o (arbGnt),
        .idx_o   (arbIdx),
        .valid_o (arbValid)
    );

    // A swap whose latched indices fall outside the bank is carried through
    // the normal four-cycle sequence but writes nothing and flags err.
    assign idxErr = (int'(aIdx_q) >= N_REGS) || (int'(bIdx_q) >= N_REGS);

    // State register and round-robin pointer. Reset drops any in-flight swap
    // on the spot; since the bank is only written on the WRITE edge, nothing
    // of an abandoned swap reaches the registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state and output decode. Outputs depend only on the current state
    // and the latched winner, so every pulse lasts exactly one cycle. The
    // pointer moves past the winner during GRANT so that it becomes the
    // lowest-priority requester at the next arbitration.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_o     = '0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        done_id_o = '0;
        err_o     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (arbValid) begin
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                gnt_o   = winGnt_q;
                busy_o  = 1'b1;
                ptr_d   = IW'((int'(winIdx_q) + 1) % N_REQ);
                state_d = S_LOAD;
            end
            S_LOAD: begin
                busy_o  = 1'b1;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                busy_o    = 1'b1;
                done_o    = 1'b1;
                done_id_o = winIdx_q;
                err_o     = idxErr;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Capture the winner and its two indices at the IDLE edge that selects
    // it. Later changes on the index inputs are deliberately ignored.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            winIdx_q <= '0;
            winGnt_q <= '0;
            aIdx_q   <= '0;
            bIdx_q   <= '0;
        end else if (state_q == S_IDLE && arbValid) begin
            winIdx_q <= arbIdx;
            winGnt_q <= arbGnt;
            aIdx_q   <= idx_a_i[int'(arbIdx)*AW +: AW];
            bIdx_q   <= idx_b_i[int'(arbIdx)*AW +: AW];
        end
    end

    // Bank read muxes: the two swap operands and the observation port. The
    // index width can address more entries than the bank holds, so an index
    // that matches no entry simply reads as zero.
    always_comb begin
        regA      = '0;
        regB      = '0;
        rd_data_o = '0;
        for (int i = 0; i < N_REGS; i++) begin
            if (aIdx_q == AW'(i)) begin
                regA = regs_q[i];
            end
            if (bIdx_q == AW'(i)) begin
                regB = regs_q[i];
            end
            if (rd_idx_i == AW'(i)) begin
                rd_data_o = regs_q[i];
            end
        end
    end

    // The temps hold both operands so the write-back can update both entries
    // on one edge without reading a half-written bank.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tempA_q <= '0;
            tempB_q <= '0;
        end else if (state_q == S_LOAD) begin
            tempA_q <= regA;
            tempB_q <= regB;
        end
    end

    // Register bank. Both entries are written on the WRITE edge; when the two
    // indices are equal both writes target the same entry with the same
    // value, so the swap degenerates into a harmless no-op.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_REGS; i++) begin
                regs_q[i] <= DW'(rst_val(i));
            end
        end else if (state_q == S_WRITE && !idxErr) begin
            for (int i = 0; i < N_REGS; i++) begin
                if (aIdx_q == AW'(i)) begin
                    regs_q[i] <= tempB_q;
                end
                if (bIdx_q == AW'(i)) begin
                    regs_q[i] <= tempA_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_swap_scheduler.sv
// ----------------------------------------------------------------------------
// tb_swap_scheduler
// Bench for swap_scheduler built with a six-entry bank (N_REGS=6, AW=3) so
// that indices 6 and 7 are out of range. A transaction-level model predicts
// every output for every cycle; directed scenarios add literal expectations,
// followed by a randomized phase with random resets.
// ----------------------------------------------------------------------------
module tb_swap_scheduler;

    localparam int N_REQ  = 4;
    localparam int N_REGS = 6;
    localparam int AW     = 3;
    localparam int DW     = 8;
    localparam int IW     = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [N_REQ-1:0]    req;
    logic [N_REQ*AW-1:0] idxA, idxB;
    logic [N_REQ-1:0]    gnt;
    logic                busy, done, err;
    logic [IW-1:0]       doneId;
    logic [AW-1:0]       rdIdx;
    logic [DW-1:0]       rdData;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    swap_scheduler #(
        .N_REQ  (N_REQ),
        .N_REGS (N_REGS),
        .AW     (AW),
        .DW     (DW)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (req),
        .idx_a_i   (idxA),
        .idx_b_i   (idxB),
        .gnt_o     (gnt),
        .busy_o    (busy),
        .done_o    (done),
        .done_id_o (doneId),
        .err_o     (err),
        .rd_idx_i  (rdIdx),
        .rd_data_o (rdData)
    );

    // One comparison: counts it, and reports a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (time %0t)",
                     name, actual, expected, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model. A swap selected at edge s shows its grant in
    // the cycle after s, is busy through s+2, reports done in the cycle
    // after s+2 and lands in the bank at edge s+3; the next arbitration can
    // happen at edge s+4. Any reset edge wipes everything.
    // ------------------------------------------------------------------
    int   edgeCnt = 0;
    int   mReg [8];
    bit   modelReady = 1'b0;
    bit   mPending;
    int   mSel, mW, mA, mB, mPtr, mFreeAt, cand, tmp;
    logic [N_REQ-1:0] expGnt;
    bit   expBusy, expDone, expErr;
    int   expId;

    always @(posedge clk) begin
        edgeCnt++;
        if (rst) begin
            for (int i = 0; i < 8; i++) mReg[i] = (i < N_REGS) ? (10 * (i + 1)) % 256 : 0;
            mPending   = 1'b0;
            mPtr       = 0;
            mFreeAt    = edgeCnt + 1;
            modelReady = 1'b1;
        end else if (modelReady) begin
            if (mPending && edgeCnt == mSel + 3) begin
                if (mA < N_REGS && mB < N_REGS) begin
                    tmp = mReg[mA]; mReg[mA] = mReg[mB]; mReg[mB] = tmp;
                end
                mPending = 1'b0;
            end
            if (!mPending && edgeCnt >= mFreeAt && req != '0) begin
                mW = -1;
                for (int k = 0; k < N_REQ; k++) begin
                    cand = (mPtr + k) % N_REQ;
                    if (mW < 0 && req[cand]) mW = cand;
                end
                mA       = int'(idxA[mW*AW +: AW]);
                mB       = int'(idxB[mW*AW +: AW]);
                mSel     = edgeCnt;
                mFreeAt  = edgeCnt + 4;
                mPtr     = (mW + 1) % N_REQ;
                mPending = 1'b1;
            end
        end
        expGnt = '0; expBusy = 1'b0; expDone = 1'b0; expErr = 1'b0; expId = 0;
        if (modelReady && !rst && mPending) begin
            expBusy = 1'b1;
            if (edgeCnt == mSel) expGnt[mW] = 1'b1;
            if (edgeCnt == mSel + 2) begin
                expDone = 1'b1;
                expId   = mW;
                expErr  = !(mA < N_REGS && mB < N_REGS);
            end
        end
    end

    // Compare process: every cycle once the model has seen a reset.
    always @(negedge clk) begin
        if (modelReady) begin
            checkOutput("gnt", 32'(gnt), 32'(expGnt));
            checkOutput("busy", 32'(busy), 32'(expBusy));
            checkOutput("done", 32'(done), 32'(expDone));
            checkOutput("done_id", 32'(doneId), expId);
            checkOutput("err", 32'(err), 32'(expErr));
            checkOutput("rd_data", 32'(rdData), mReg[rdIdx]);
        end
    end

    // Event log of observed grants and completions, used by directed tests.
    int gntIds[$], gntEdges[$], doneIds[$], doneEdges[$], doneErrs[$];

    always @(negedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i] === 1'b1) begin
                gntIds.push_back(i);
                gntEdges.push_back(edgeCnt);
            end
        end
        if (done === 1'b1) begin
            doneIds.push_back(int'(doneId));
            doneEdges.push_back(edgeCnt);
            doneErrs.push_back(int'(err));
        end
    end

    // Requester driver: drops a request right after its grant; in random
    // mode it also raises, withdraws and perturbs requests, moves the read
    // address and injects occasional resets.
    bit randomMode = 1'b0;

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i] === 1'b1) begin
                req[i] = 1'b0;
            end else if (randomMode) begin
                if (!req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req[i] = 1'b1;
                        idxA[i*AW +: AW] = 3'($urandom_range(0, 7));
                        idxB[i*AW +: AW] = 3'($urandom_range(0, 7));
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    req[i] = 1'b0;
                end else if ($urandom_range(0, 9) == 0) begin
                    idxA[i*AW +: AW] = 3'($urandom_range(0, 7));
                end
            end
        end
        if (randomMode) begin
            rdIdx = 3'($urandom_range(0, 7));
            rst   = ($urandom_range(0, 79) == 0);
        end
    end

    // Directed helpers; inputs change 2 time units after a rising edge.
    task automatic clearLogs();
        gntIds.delete(); gntEdges.delete();
        doneIds.delete(); doneEdges.delete(); doneErrs.delete();
    endtask

    task automatic applyStimulus(input int id, input int a, input int b);
        idxA[id*AW +: AW] = 3'(a);
        idxB[id*AW +: AW] = 3'(b);
        req[id] = 1'b1;
    endtask

    task automatic doReset();
        @(posedge clk); #2; rst = 1'b1;
        @(posedge clk); #2; rst = 1'b0;
    endtask

    task automatic waitIdle(input int maxCycles, input string tag);
        int n;
        n = 0;
        do begin
            @(posedge clk); #2;
            n++;
        end while ((req != '0 || busy !== 1'b0) && n < maxCycles);
        if (req != '0 || busy !== 1'b0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: still busy after %0d cycles, expected idle", tag, n);
        end
    endtask

    task automatic readCheck(input string name, input int idx, input int expected);
        @(posedge clk); #2; rdIdx = 3'(idx);
        @(negedge clk); #1;
        checkOutput(name, 32'(rdData), expected);
    endtask

    int rstLit [8] = '{10, 20, 30, 40, 50, 60, 0, 0};
    int ordLit [9] = '{0, 1, 2, 3, 1, 2, 3, 0, 1};
    int reqEdge;

    initial begin
        rst = 1'b1; req = '0; idxA = '0; idxB = '0; rdIdx = '0;
        repeat (2) @(posedge clk);
        #2; rst = 1'b0;

        $display("[TB] test 1: reset contents");
        for (int i = 0; i < 8; i++) readCheck("t1_reset_rd", i, rstLit[i]);

        $display("[TB] test 2: single swap 0<->1 latency");
        clearLogs();
        @(posedge clk); #2;
        applyStimulus(0, 0, 1);
        reqEdge = edgeCnt + 1;
        waitIdle(20, "t2");
        checkOutput("t2_gnt_count", gntIds.size(), 1);
        checkOutput("t2_gnt_edge", (gntEdges.size() > 0) ? gntEdges[0] : -1, reqEdge);
        checkOutput("t2_done_edge", (doneEdges.size() > 0) ? doneEdges[0] : -1, reqEdge + 2);
        checkOutput("t2_done_id", (doneIds.size() > 0) ? doneIds[0] : -1, 0);
        readCheck("t2_reg0", 0, 20);
        readCheck("t2_reg1", 1, 10);

        $display("[TB] test 3: round-robin order");
        doReset();
        clearLogs();
        for (int i = 0; i < N_REQ; i++) applyStimulus(i, 4, 4);
        waitIdle(60, "t3a");
        applyStimulus(1, 4, 4);
        waitIdle(20, "t3b");
        for (int i = 0; i < N_REQ; i++) applyStimulus(i, 4, 4);
        waitIdle(60, "t3c");
        checkOutput("t3_gnt_count", gntIds.size(), 9);
        for (int i = 0; i < 9; i++)
            checkOutput("t3_order", (i < gntIds.size()) ? gntIds[i] : -1, ordLit[i]);

        $display("[TB] test 4: a==b and out-of-range index");
        doReset();
        clearLogs();
        applyStimulus(2, 5, 5);
        reqEdge = edgeCnt + 1;
        waitIdle(20, "t4a");
        checkOutput("t4_done_edge", (doneEdges.size() > 0) ? doneEdges[0] : -1, reqEdge + 2);
        checkOutput("t4_err_same", (doneErrs.size() > 0) ? doneErrs[0] : -1, 0);
        readCheck("t4_reg5", 5, 60);
        applyStimulus(2, 3, 7);
        waitIdle(20, "t4b");
        checkOutput("t4_done_id", (doneIds.size() > 1) ? doneIds[1] : -1, 2);
        checkOutput("t4_err_range", (doneErrs.size() > 1) ? doneErrs[1] : -1, 1);
        readCheck("t4_reg3", 3, 40);

        $display("[TB] test 5: reset during LOAD");
        doReset();
        clearLogs();
        applyStimulus(0, 0, 1);
        @(posedge clk);
        @(posedge clk); #2; rst = 1'b1;
        @(posedge clk); #2; rst = 1'b0;
        @(negedge clk); #1;
        checkOutput("t5_busy", 32'(busy), 0);
        checkOutput("t5_done_count", doneIds.size(), 0);
        readCheck("t5_reg0", 0, 10);
        readCheck("t5_reg1", 1, 20);

        $display("[TB] test 6: back-to-back swaps");
        doReset();
        clearLogs();
        applyStimulus(0, 0, 1);
        applyStimulus(1, 1, 2);
        waitIdle(40, "t6");
        checkOutput("t6_done_count", doneIds.size(), 2);
        checkOutput("t6_done_gap", (doneEdges.size() > 1) ? doneEdges[1] - doneEdges[0] : -1, 4);
        readCheck("t6_reg0", 0, 20);
        readCheck("t6_reg1", 1, 30);
        readCheck("t6_reg2", 2, 10);

        $display("[TB] random phase");
        @(posedge clk);
        randomMode = 1'b1;
        repeat (3000) @(posedge clk);
        randomMode = 1'b0;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
